divu8by4_seq: RTL and testbench

- Sequential unsigned restoring divider: the inverse operation of the library's combinational 4-bit unsigned multipliers.
- Takes an 8-bit dividend (the full range of a 4x4 product) and a 4-bit divisor; returns an 8-bit quotient and a 4-bit remainder.
- Produces one quotient bit per clock behind a valid/ready handshake.
- Serves as the golden round-trip checker: multiplier output feeds the dividend, a multiplier operand feeds the divisor, and the block recovers the other operand in fault-injection benches.

---
 rtl/divu_pkg.sv | 21 ++
 rtl/divu8by4_seq_if.sv | 27 ++
 rtl/divu_step.sv | 18 +
 rtl/divu8by4_seq.sv | 111 +++++++++++
 tb/tb_divu8by4_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/divu_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package divu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;

   // Bits needed to hold values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/divu8by4_seq_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
interface divu8by4_seq_if
   import divu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract D.
module divu_step #(
   parameter int VW = 4
) (
   input  logic [VW-1:0] i_r,
   input  logic          i_bit,
   input  logic [VW-1:0] i_d,
   output logic [VW:0]   o_r,
   output logic          o_q
);
   logic [VW:0] w_t;
   logic [VW:0] w_d;

   assign w_t = {i_r, i_bit};
   assign w_d = {1'b0, i_d};
   assign o_q = (w_t >= w_d);
   assign o_r = o_q ? (w_t - w_d) : w_t;
endmodule

// File: rtl/divu8by4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Zero divisor short-circuits to an all-ones quotient with div_by_zero set.
module divu8by4_seq
   import divu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   divu8by4_seq_if.slave bus
);
   localparam int            CW       = (clog2(DW) < 1) ? 1 : clog2(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   state_e        r_state;
   logic [DW-1:0] r_q;
   logic [VW:0]   r_r;
   logic [VW-1:0] r_d;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_quot;
   logic [VW-1:0] r_rem;
   logic          r_in_ready;
   logic          r_out_valid;
   logic          r_dbz;

   logic [VW:0]   w_r_next;
   logic          w_q_bit;
   logic [DW-1:0] w_q_next;
   logic          w_unused_r_msb;

   divu_step #(.VW(VW)) u_step (
      .i_r   (r_r[VW-1:0]),
      .i_bit (r_q[DW-1]),
      .i_d   (r_d),
      .o_r   (w_r_next),
      .o_q   (w_q_bit)
   );

   assign w_q_next       = {r_q[DW-2:0], w_q_bit};
   // The partial remainder never exceeds D after a step, so its top bit only matters inside the step.
   assign w_unused_r_msb = r_r[VW];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_q         <= '0;
         r_r         <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  if (bus.divisor != '0) begin
                     r_q     <= bus.dividend;
                     r_d     <= bus.divisor;
                     r_r     <= '0;
                     r_cnt   <= CNT_LAST;
                     r_state <= BUSY;
                  end else begin
                     r_quot      <= '1;
                     r_rem       <= '0;
                     r_dbz       <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            BUSY: begin
               r_q <= w_q_next;
               r_r <= w_r_next;
               if (r_cnt == '0) begin
                  r_quot      <= w_q_next;
                  r_rem       <= w_r_next[VW-1:0];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               // Ready returns one cycle after the result is taken, never in the same cycle.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_dbz       <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divu8by4_seq.sv
// Directed and exhaustive checks of divu8by4_seq against a queued reference model.
module tb_divu8by4_seq;

   typedef struct {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   divu8by4_seq_if bus ();

   divu8by4_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic drive_op(input logic [7:0] a, input logic [3:0] b);
      int   n;
      exp_t e;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      if (b == 4'd0) begin
         e.q = 8'hFF;
         e.r = 4'd0;
         e.z = 1'b1;
      end else begin
         e.q = a / {4'd0, b};
         e.r = 4'(a % {4'd0, b});
         e.z = 1'b0;
      end
      sb.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_check(input string tag, input int exp_lat);
      int   edges;
      exp_t e;
      edges = 1;
      while (bus.out_valid !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      check({tag, "_latency"}, edges, exp_lat);
      if (sb.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_quotient"}, {24'd0, bus.quotient}, {24'd0, e.q});
         check({tag, "_remainder"}, {28'd0, bus.remainder}, {28'd0, e.r});
         check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.z});
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_quotient"}, {24'd0, bus.quotient}, 32'd0);
      check({tag, "_remainder"}, {28'd0, bus.remainder}, 32'd0);
      check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle_zero("reset");

      drive_op(8'd200, 4'd7);
      wait_check("d200_7", 9);
      @(negedge clk);
      check("d200_7_pulse", {31'd0, bus.out_valid}, 32'd0);
      check("d200_7_hold", {24'd0, bus.quotient}, 32'd28);

      drive_op(8'd225, 4'd15);
      wait_check("d225_15", 9);
      drive_op(8'd255, 4'd1);
      wait_check("d255_1", 9);
      drive_op(8'd5, 4'd9);
      wait_check("d5_9", 9);

      drive_op(8'd77, 4'd0);
      wait_check("d77_0", 1);
      @(negedge clk);
      check("d77_0_dbz_clear", {31'd0, bus.div_by_zero}, 32'd0);
      check("d77_0_valid_drop", {31'd0, bus.out_valid}, 32'd0);
      check("d77_0_quot_hold", {24'd0, bus.quotient}, 32'd255);

      // Result held under backpressure while a second request waits.
      bus.out_ready = 1'b0;
      drive_op(8'd50, 4'd6);
      wait_check("bp_first", 9);
      bus.in_valid = 1'b1;
      bus.dividend = 8'd99;
      bus.divisor  = 4'd4;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_quot_hold", {24'd0, bus.quotient}, 32'd8);
         check("bp_rem_hold", {28'd0, bus.remainder}, 32'd2);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
      drive_op(8'd99, 4'd4);
      wait_check("bp_second", 9);

      // Abort in the 4th BUSY cycle.
      drive_op(8'd200, 4'd7);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      check_idle_zero("abort");
      drive_op(8'd100, 4'd3);
      wait_check("d100_3", 9);

      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            drive_op(8'(a), 4'(b));
            wait_check("sweep", 9);
         end
      end
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
